// File: rtl/thr_pkg.sv
// Shared types and default constants for the pitch-antenna tuner.
package thr_pkg;

  localparam int unsigned TW_W           = 32;
  localparam int unsigned DEF_MAX_WORD   = 8796115;
  localparam int unsigned DEF_CAL_PERIOD = 1000;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous square wave plus a registered
// single-cycle rising-edge pulse.
module sync_edge (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
      rise <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
      rise <= sync & ~prev;
    end
  end

endmodule

// File: rtl/pitch_tuner.sv
// Measures the antenna oscillator period against a calibrated reference and
// produces a smoothed, saturated DDS phase increment.
module pitch_tuner
  import thr_pkg::*;
#(
  parameter int unsigned CNT_W        = 20,
  parameter int unsigned TIMEOUT      = 1000000,
  parameter int unsigned MIN_PERIOD   = 4,
  parameter int unsigned GAIN_SHIFT   = 8,
  parameter int unsigned SMOOTH_SHIFT = 3,
  parameter int unsigned MAX_WORD     = DEF_MAX_WORD,
  parameter int unsigned CAL_DEFAULT  = DEF_CAL_PERIOD
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sensor_in,
  input  logic             calibrate,
  output logic [TW_W-1:0]  tuningWord,
  output logic             word_valid,
  output logic [CNT_W-1:0] period_out,
  output logic             cal_done,
  output logic             no_signal
);

  logic                   rise;
  state_t                 state;
  state_t                 state_next;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cal_period;
  logic                   cal_pending;
  logic                   p1_valid;
  logic                   p1_cal;
  logic [CNT_W-1:0]       p1_delta;
  logic                   p2_valid;
  logic                   p2_cal;
  logic [TW_W-1:0]        p2_target;
  logic signed [TW_W:0]   filt;
  logic                   arm_c;
  logic                   accept_c;
  logic                   timeout_c;
  logic                   cal_hit_c;
  logic [TW_W-1:0]        gained_c;
  logic [TW_W-1:0]        target_c;
  logic signed [TW_W:0]   diff_c;
  logic signed [TW_W:0]   filt_next_c;

  sync_edge u_sync_edge (
    .clock (clock),
    .reset (reset),
    .din   (sensor_in),
    .rise  (rise)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (timeout_c)  state_next = IDLE;
    else if (arm_c) state_next = MEASURE;
  end

  // The first edge after silence only arms the counter; later edges close a period.
  always_comb begin
    arm_c    = 1'b0;
    accept_c = 1'b0;
    case (state)
      IDLE:    arm_c    = rise;
      MEASURE: accept_c = rise && (cnt >= CNT_W'(MIN_PERIOD));
      default: ;
    endcase
  end

  // Counter parks at TIMEOUT, so the timeout fires once on the step into it.
  assign timeout_c = !rise && (cnt == CNT_W'(TIMEOUT - 1));
  assign cal_hit_c = accept_c && (cal_pending || calibrate);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                     cnt <= CNT_W'(TIMEOUT);
    else if (rise)                  cnt <= CNT_W'(1);
    else if (cnt != CNT_W'(TIMEOUT)) cnt <= cnt + CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cal_pending <= 1'b0;
      cal_period  <= CNT_W'(CAL_DEFAULT);
    end else if (cal_hit_c) begin
      cal_pending <= 1'b0;
      cal_period  <= cnt;
    end else if (calibrate) begin
      cal_pending <= 1'b1;
    end
  end

  // P1: latch the period and how far it sits below the reference.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      p1_valid   <= 1'b0;
      p1_cal     <= 1'b0;
      p1_delta   <= '0;
      period_out <= '0;
      cal_done   <= 1'b0;
    end else begin
      p1_valid <= accept_c;
      p1_cal   <= cal_hit_c;
      cal_done <= cal_hit_c;
      if (accept_c) begin
        period_out <= cnt;
        p1_delta   <= (cal_period > cnt) ? cal_period - cnt : '0;
      end
    end
  end

  assign gained_c = TW_W'(p1_delta) << GAIN_SHIFT;
  assign target_c = (gained_c > TW_W'(MAX_WORD)) ? TW_W'(MAX_WORD) : gained_c;

  // P2: scaled and clamped target word.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      p2_valid  <= 1'b0;
      p2_cal    <= 1'b0;
      p2_target <= '0;
    end else begin
      p2_valid <= p1_valid;
      p2_cal   <= p1_cal;
      if (p1_valid) p2_target <= target_c;
    end
  end

  assign diff_c      = $signed({1'b0, p2_target}) - filt;
  assign filt_next_c = filt + (diff_c >>> SMOOTH_SHIFT);

  // P3: first-order IIR toward the target; calibration and timeout zero it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      filt       <= '0;
      tuningWord <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (timeout_c) begin
        filt       <= '0;
        tuningWord <= '0;
        word_valid <= 1'b1;
      end else if (p2_valid) begin
        word_valid <= 1'b1;
        if (p2_cal) begin
          filt       <= '0;
          tuningWord <= '0;
        end else begin
          filt       <= filt_next_c;
          tuningWord <= filt_next_c[TW_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)         no_signal <= 1'b1;
    else if (timeout_c) no_signal <= 1'b1;
    else if (arm_c)     no_signal <= 1'b0;
  end

endmodule

// File: doc/pitch_tuner.md
Name: pitch_tuner

Overview:
Upstream control stage for the DDS tone generator. Measures the period of the pitch-antenna oscillator square wave in clock cycles and compares it to a calibrated reference period. Converts the difference into a smoothed, saturated 32-bit phase-increment tuningWord that drives the DDS directly. Also flags calibration completion, loss of signal, and a fresh-word strobe.

Parameters:
CNT_W, 20, period counter and period/cal width in bits
TIMEOUT, 1000000, clock cycles without a rising edge before no_signal asserts
MIN_PERIOD, 4, shortest accepted period; shorter periods are glitches and are discarded
GAIN_SHIFT, 8, left shift applied to the period delta
SMOOTH_SHIFT, 3, IIR smoothing shift; filt += (target - filt) >>> SMOOTH_SHIFT
MAX_WORD, 8796115, saturation ceiling for tuningWord
CAL_DEFAULT, 1000, cal_period value after reset

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
sensor_in  in  1  asynchronous oscillator square wave from the antenna front end
calibrate  in  1  one-cycle pulse; the next valid period becomes cal_period
tuningWord  out  32  DDS phase increment
word_valid  out  1  one-cycle pulse when tuningWord updates
period_out  out  CNT_W  last accepted period
cal_done  out  1  one-cycle pulse when cal_period is loaded
no_signal  out  1  high while the sensor is deemed absent

Behaviour:
- Reset (reset=0, async): tuningWord=0, word_valid=0, period_out=0, cal_done=0, no_signal=1, cal_period=CAL_DEFAULT, filt=0, cal_pending=0, state=IDLE.
- Input conditioning: 2-FF synchronizer plus edge register. A rising edge on sensor_in is detected 3 clocks later as rise (1 cycle).
- Counter cnt: set to 1 on rise, otherwise increments. Saturates at TIMEOUT. On rise, measured period = cnt value (cycle distance between detected rises).
- States:
  - IDLE: wait for rise → MEASURE (no period captured); clear no_signal.
  - MEASURE: on rise with cnt < MIN_PERIOD → discard, stay, cnt restarts at 1. On rise with cnt >= MIN_PERIOD → capture period, launch the pipeline.
  - Any state: cnt reaching TIMEOUT → no_signal=1, tuningWord=0, filt=0, word_valid pulse, → IDLE.
- Compute pipeline (fully pipelined; a new period may enter every cycle):
  - P1: period_out<=period; delta = cal_period > period ? cal_period - period : 0.
  - P2: target = min(delta << GAIN_SHIFT, MAX_WORD), computed in 32 bits with no overflow (CNT_W+GAIN_SHIFT <= 32).
  - P3: filt <= filt + ((target - filt) >>> SMOOTH_SHIFT), 33-bit signed arithmetic; tuningWord<=filt_next; word_valid=1.
  - Latency: rise → tuningWord/word_valid at rise+3.
- Calibration:
  - calibrate sets cal_pending.
  - The next accepted period loads cal_period, pulses cal_done in P1, clears cal_pending, and forces filt=0 and tuningWord=0 (word_valid pulses at P3).
  - calibrate arriving in the same cycle as an accepted rise applies to that period.
  - Repeated calibrate while pending has no extra effect.
- Period > cal_period gives target 0, and filt decays toward 0.
- Reset mid-pipeline drops all in-flight data; no word_valid is emitted.

Decomposition:
- Package thr_pkg holds: tuning-word width (32), state enum {IDLE, MEASURE}, default constants (MAX_WORD, CAL_DEFAULT).
- One sub-module, sync_edge: 2-FF synchronizer plus rising-edge pulse, with async active-low reset to 0.
- Counter, FSM, pipeline and filter stay in pitch_tuner.

Test Plan:
- Calibration: sensor period 1000 clk, pulse calibrate → cal_done 1 pulse, cal_period=1000, tuningWord=0, no_signal=0.
- Filter steps: after cal, period 900 → first word_valid tuningWord=3200, next 6000 (target 25600); steady input converges to 25600 within ±7.
- Saturation: cal_period 60000, period 100 → target clamps to 8796115; tuningWord rises monotonically and never exceeds 8796115.
- Timeout: stop sensor → exactly TIMEOUT clocks after the last rise, no_signal=1, tuningWord=0, word_valid pulse; the restarted sensor needs two rises before the next word.
- Glitch and short-period handling: a 2-clk period is discarded (no word_valid, period_out unchanged). A period of 1100 with cal 1000 → target 0.
- Mid-operation reset: assert reset between P1 and P3 → all outputs return to reset values immediately; no word_valid after release until a new period completes.
